if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch pipeline stage that sits directly upstream of the decode stage. It owns the fetch PC and drives a single-outstanding request/acknowledge instruction-memory port. It fills the IF/ID pipeline register (pc, if_pc, if_insn, if_en, if_hart_st) that decode consumes. It honours stall and flush from the control unit and taken-branch redirects from execute, and safely drains an in-flight fetch whenever it is redirected.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0013, instruction loaded into if_insn on reset, flush or redirect (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold IF/ID register
flush  in  1  discard IF/ID contents and redirect to new_pc
new_pc  in  32  flush target (exception vector / ERET return)
br_taken  in  1  taken branch/jump redirect
br_addr  in  32  branch target
hart_st  in  `HART_STATE_B  current hart state, forwarded with each instruction
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  read data valid; may assert in the same cycle as imem_req
imem_rd_data  in  32  fetched word
pc  out  32  address of if_insn
if_pc  out  32  pc+4
if_insn  out  32  fetched instruction
if_en  out  1  IF/ID entry valid
if_hart_st  out  `HART_STATE_B  hart state captured with the instruction

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_VECTOR, if_pc=RESET_VECTOR+4, if_insn=NOP_INSN, if_en=0, if_hart_st=0.
  - imem_req=0, fetch_pc=RESET_VECTOR, squash=0, state=IDLE.
  - Reset asserted mid-request abandons the request; memory discards it.
- FSM states: IDLE, FETCH, HOLD, DRAIN.
  - IDLE: imem_req=0. Next edge -> FETCH.
  - FETCH: imem_req=1, imem_addr=fetch_pc. imem_addr stays stable until imem_ack.
    - ack with no stall and no redirect: IF/ID <= {fetch_pc, fetch_pc+4, imem_rd_data, 1, hart_st}; fetch_pc += 4; remain in FETCH. Zero-wait memory sustains 1 insn/cycle.
    - no ack and no stall: if_en <= 0 (bubble); other IF/ID fields hold.
    - ack with stall: IF/ID holds; data and hart_st go into the hold buffer; fetch_pc += 4; -> HOLD.
    - no ack with stall: IF/ID holds; keep requesting.
  - HOLD: imem_req=0. When stall=0, IF/ID <= hold buffer with if_en=1 -> FETCH.
  - DRAIN: imem_req=1 with the old address. When ack arrives, discard the data -> FETCH at fetch_pc.
- Redirect:
  - flush has priority over br_taken; target = flush ? new_pc : br_addr.
  - Any redirect overrides stall. IF/ID <= {pc unchanged, if_pc unchanged, NOP_INSN, if_en=0}. fetch_pc <= target with bits[1:0] forced to 0. Hold buffer is invalidated.
  - If in FETCH with no ack this cycle -> DRAIN. Otherwise (ack this cycle, or IDLE/HOLD/DRAIN-with-ack) the data is discarded -> FETCH.
  - Redirect while already in DRAIN: update fetch_pc and stay in DRAIN until ack.
- fetch_pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- if_pc is always pc+4 at capture time.

Optional Feature:
- Macro IF_MISALIGN_EXP_EN.
- Defined:
  - Adds output if_exp_code (`EXP_CODE_BUS`).
  - A redirect target with bits[1:0]!=0 is not fetched. Next cycle IF/ID <= {pc=target, if_pc=target+4, NOP_INSN, if_en=1, if_exp_code=`EXP_MISS_ALIGN}, then fetching proceeds from target aligned.
  - if_exp_code=`EXP_NO_EXP otherwise, and on reset.
- Undefined: port absent; target low bits silently cleared.

Test Plan:
- Reset release, zero-wait memory (ack same cycle), words 0x13,0x93,... -> pc 0,4,8 on consecutive cycles, if_en=1 from the 2nd cycle after release, if_pc=pc+4.
- ack delayed 2 cycles per fetch -> if_en toggles 0,0,1 per fetch, imem_addr stable across wait cycles, no duplicate or skipped pc.
- stall=1 for 3 cycles while an ack lands -> IF/ID unchanged, imem_req=0 in HOLD; on stall release the buffered insn appears with correct pc, nothing lost.
- Request at 0x40 outstanding, flush with new_pc=0x100 -> if_en=0, if_insn=0x13; state DRAIN until ack (data ignored); next request addr 0x100; first valid pc=0x100.
- flush (new_pc=0x200) and br_taken (br_addr=0x300) in the same cycle, with stall=1 -> fetch resumes at 0x200, stall ignored for the redirect.
- fetch_pc=32'hFFFF_FFFC -> next imem_addr=0; with IF_MISALIGN_EXP_EN, br_addr=0x102 -> if_en=1, pc=0x102, if_exp_code=`EXP_MISS_ALIGN, then fetch at 0x100.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: owns the fetch PC, drives a single-outstanding imem port, fills IF/ID.
// Define IF_MISALIGN_EXP_EN to report misaligned redirect targets on if_exp_code.
`ifndef HART_STATE_B
`define HART_STATE_B 1:0
`endif
`ifndef EXP_CODE_BUS
`define EXP_CODE_BUS 3:0
`endif
`ifndef EXP_NO_EXP
`define EXP_NO_EXP 4'h0
`endif
`ifndef EXP_MISS_ALIGN
`define EXP_MISS_ALIGN 4'h1
`endif

module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          new_pc,
    input  logic                 br_taken,
    input  logic [31:0]          br_addr,
    input  logic [`HART_STATE_B] hart_st,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rd_data,
    output logic [31:0]          pc,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_insn,
    output logic                 if_en,
`ifdef IF_MISALIGN_EXP_EN
    output logic [`EXP_CODE_BUS] if_exp_code,
`endif
    output logic [`HART_STATE_B] if_hart_st
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t               state;
    logic [31:0]          fetch_pc;
    logic [31:0]          hold_pc;
    logic [31:0]          hold_insn;
    logic [`HART_STATE_B] hold_hart_st;
    logic                 redirect;
    logic [31:0]          target;
    logic [31:0]          target_al;

    assign redirect  = flush | br_taken;
    assign target    = flush ? new_pc : br_addr;
    assign target_al = target & ~32'h3;

    // Fetch FSM: request port, IF/ID register and stall hold buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_VECTOR;
            fetch_pc     <= RESET_VECTOR;
            pc           <= RESET_VECTOR;
            if_pc        <= RESET_VECTOR + 32'd4;
            if_insn      <= NOP_INSN;
            if_en        <= 1'b0;
            if_hart_st   <= '0;
            hold_pc      <= RESET_VECTOR;
            hold_insn    <= NOP_INSN;
            hold_hart_st <= '0;
`ifdef IF_MISALIGN_EXP_EN
            if_exp_code  <= `EXP_NO_EXP;
`endif
        end else if (redirect) begin
            fetch_pc <= target_al;
            if_insn  <= NOP_INSN;
            if_en    <= 1'b0;
`ifdef IF_MISALIGN_EXP_EN
            if_exp_code <= `EXP_NO_EXP;
            if (target[1:0] != 2'b00) begin
                pc          <= target;
                if_pc       <= target + 32'd4;
                if_en       <= 1'b1;
                if_hart_st  <= hart_st;
                if_exp_code <= `EXP_MISS_ALIGN;
            end
`endif
            // An unanswered request must still complete before refetching.
            if ((state == FETCH || state == DRAIN) && !imem_ack) begin
                state    <= DRAIN;
                imem_req <= 1'b1;
            end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= target_al;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (stall) begin
                            hold_pc      <= fetch_pc;
                            hold_insn    <= imem_rd_data;
                            hold_hart_st <= hart_st;
                            state        <= HOLD;
                            imem_req     <= 1'b0;
                        end else begin
                            pc         <= fetch_pc;
                            if_pc      <= fetch_pc + 32'd4;
                            if_insn    <= imem_rd_data;
                            if_en      <= 1'b1;
                            if_hart_st <= hart_st;
`ifdef IF_MISALIGN_EXP_EN
                            if_exp_code <= `EXP_NO_EXP;
`endif
                            imem_addr  <= fetch_pc + 32'd4;
                        end
                    end else if (!stall) begin
                        if_en <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc         <= hold_pc;
                        if_pc      <= hold_pc + 32'd4;
                        if_insn    <= hold_insn;
                        if_en      <= 1'b1;
                        if_hart_st <= hold_hart_st;
`ifdef IF_MISALIGN_EXP_EN
                        if_exp_code <= `EXP_NO_EXP;
`endif
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                        imem_addr  <= fetch_pc;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if_en <= 1'b0;
                    end
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
